// File: rtl/mem_arbiter_wb.sv
// Arbiter between the D and I caches and one unified memory port, with a
// one-line posted write buffer that forwards to D-side reads of the same line.
module mem_arbiter_wb #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {IDLE, RD_D, RD_I, WR, RESP, GAP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] buf_addr;
  logic [LINE_W-1:0] buf_data;
  logic              bv;
  logic              same_line;
  logic              unused_i_write;

  assign same_line      = (d_addr == buf_addr);
  assign unused_i_write = i_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bv        <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_read && bv && same_line) begin
            d_rdata <= buf_data;
            d_ready <= 1'b1;
            state   <= RESP;
          end else if (d_write && (!bv || same_line)) begin
            // Same-line write-backs simply overwrite the buffered copy.
            buf_addr <= d_addr;
            buf_data <= d_wdata;
            bv       <= 1'b1;
            d_ready  <= 1'b1;
            state    <= RESP;
          end else if (d_write || (!d_read && !i_read && bv)) begin
            // Buffer is occupied by another line, or the port is free: drain it.
            mem_write <= 1'b1;
            mem_addr  <= buf_addr;
            mem_wdata <= buf_data;
            state     <= WR;
          end else if (d_read) begin
            mem_read <= 1'b1;
            mem_addr <= d_addr;
            state    <= RD_D;
          end else if (i_read) begin
            mem_read <= 1'b1;
            mem_addr <= i_addr;
            state    <= RD_I;
          end
        end
        RD_D: begin
          if (mem_ready) begin
            d_rdata  <= mem_rdata;
            d_ready  <= 1'b1;
            mem_read <= 1'b0;
            state    <= RESP;
          end
        end
        RD_I: begin
          if (mem_ready) begin
            i_rdata  <= mem_rdata;
            i_ready  <= 1'b1;
            mem_read <= 1'b0;
            state    <= RESP;
          end
        end
        WR: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            bv        <= 1'b0;
            state     <= GAP;
          end
        end
        RESP: begin
          d_ready <= 1'b0;
          i_ready <= 1'b0;
          state   <= GAP;
        end
        GAP: begin
          // Idle cycle so requesters can drop held requests and memory rests.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter_wb.md
Name: mem_arbiter_wb

Overview:
- Sits between the two caches (D and I) and a single unified slow-memory port; one per chip.
- Arbitrates line reads from both caches.
- Posts D-cache write-backs into a one-line write buffer, which drains to memory when the port is free.
- Read-after-write to a buffered line is forwarded from the buffer, so the D cache never observes stale data.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_read  in  1  D-cache line read request; held until d_ready.
- d_write  in  1  D-cache line write-back request; held until d_ready.
- d_addr  in  ADDR_W  D line address.
- d_wdata  in  LINE_W  D write-back data.
- d_rdata  out  LINE_W  D read data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse to D.
- i_read  in  1  I-cache line read request; held until i_ready.
- i_write  in  1  unused (I side is read-only); ignored.
- i_addr  in  ADDR_W  I line address.
- i_rdata  out  LINE_W  I read data; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse to I.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data; valid while mem_ready=1.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- Reset:
  - All outputs are registered and go to 0 on rst.
  - State returns to IDLE and the buffer valid bit (bv) clears.
  - Reset mid-transfer abandons the transfer; buffered data is discarded.
- States: IDLE, RD_D, RD_I, WR, RESP, GAP.
- Buffer: registers buf_addr, buf_data, bv.
- IDLE priority, evaluated each cycle, first match wins:
  1. d_read & bv & d_addr==buf_addr -> d_rdata<=buf_data; go to RESP(D).
  2. d_write & (!bv | d_addr==buf_addr) -> buf_addr/buf_data<=d_addr/d_wdata, bv<=1; go to RESP(D). Same-address writes coalesce by overwrite.
  3. d_write & bv & d_addr!=buf_addr -> drain first; go to WR.
  4. d_read -> mem_read<=1, mem_addr<=d_addr; go to RD_D.
  5. i_read -> mem_read<=1, mem_addr<=i_addr; go to RD_I.
  6. bv -> go to WR.
  7. Otherwise stay in IDLE.
- WR:
  - mem_write=1, mem_addr=buf_addr, mem_wdata=buf_data, set on entry and held stable.
  - On mem_ready: mem_write<=0, bv<=0; go to GAP.
- RD_D / RD_I:
  - mem_read and mem_addr are held stable.
  - On mem_ready: capture mem_rdata into d_rdata or i_rdata, mem_read<=0; go to RESP of that requester.
- RESP(x): x_ready=1 for exactly this one cycle; go to GAP.
- GAP:
  - One cycle with all requests ignored and mem_read=mem_write=0.
  - Lets the requester drop its held request and gives memory an idle cycle.
  - Go to IDLE.
- Latency, forward hit or posted write: request seen in IDLE at cycle t, ready at t+1.
- Latency, memory read: request in IDLE at t, mem_read at t+1, mem_ready at m, ready at m+1.
- Memory-side rules:
  - mem_read and mem_write are never both 1.
  - Memory outputs do not change while a request is outstanding.
  - A new memory request is issued at least 2 cycles after the previous mem_ready.
- d_read with d_addr!=buf_addr may bypass a buffered write; this is ordering-safe because the addresses differ.
- d_read and d_write asserted together violates the D-cache protocol; priority order applies, with no further guarantee.
- A D request and an I request arriving in the same cycle: D is served first; I waits in IDLE, holding its request.
- mem_ready received outside RD_D, RD_I or WR is ignored.
- i_write has no effect.

Test Plan:
1. Reset: rst=1 for 2 cycles during a mid RD_I transfer -> all outputs 0 on the next cycle; bv=0; a stale mem_ready after reset gives no i_ready.
2. I read:
   - Stimulus: i_read, i_addr=0x0000010; memory ready 5 cycles after mem_read.
   - Required: mem_read=1 with mem_addr=0x0000010 one cycle after the request.
   - Required: i_rdata=mem_rdata and i_ready pulses 1 cycle after mem_ready.
   - Required: mem_read=0 for at least 2 cycles afterwards.
3. Posted write then forward:
   - Stimulus: d_write, addr 0x0000020, data 0xA5..A5.
   - Required: d_ready at t+1 with no mem_write issued.
   - Stimulus: d_read of 0x0000020 right after.
   - Required: d_rdata=0xA5..A5 after 1 cycle with no mem_read; buffer later drains via mem_write, addr 0x0000020.
4. Simultaneous:
   - Stimulus: d_read 0x30 and i_read 0x40 in the same cycle.
   - Required: memory sees 0x30 first, then 0x40; each requester gets exactly one ready pulse with its own data.
5. Buffer full:
   - Stimulus: bv holds 0x50; d_write to 0x60.
   - Required: mem_write of 0x50 completes before d_ready.
   - Required: buffer then holds 0x60, which drains when idle.
6. Coalesce: two d_writes to 0x70 with data X then Y before any drain -> exactly one mem_write, with data Y.
